// File: rtl/hs_fifo_pkg.sv
// Shared types for hs_fifo: handshake FSM encodings, status flag bundle, clog2 helper.
package hs_fifo_pkg;

  typedef enum logic {TX_IDLE, TX_ACK} tx_state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_VALID, RX_WAIT} rx_state_t;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } flags_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// Register-array storage for hs_fifo: one synchronous write port, one asynchronous read port.
module hs_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/hs_fifo.sv
// Four-phase handshake FIFO with registered head word and status flags.
// Optional macro HS_FIFO_FLUSH_EN adds a synchronous flush input.
module hs_fifo
  import hs_fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 5,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tx_rdy,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       tx_done,
  output logic                       rx_rdy,
  input  logic                       rx_done,
  output logic [WIDTH-1:0]           out_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [clog2(DEPTH+1)-1:0]  count
`ifdef HS_FIFO_FLUSH_EN
  ,
  input  logic                       flush
`endif
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  localparam logic [CW-1:0] AF_TH = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_TH = CW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);

`ifndef HS_FIFO_FLUSH_EN
  logic flush;
  assign flush = 1'b0;
`endif

  tx_state_t        tx_st;
  rx_state_t        rx_st;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rd_word;
  logic             push, pop, wr_en;
  logic [CW-1:0]    count_nxt;
  flags_t           flags_nxt;

  // Push qualifies on the registered full flag, so a same-edge pop cannot free a slot early.
  assign push  = (tx_st == TX_IDLE) && tx_rdy && !full;
  assign pop   = (rx_st == RX_VALID) && rx_done && !flush;
  assign wr_en = push && !flush;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    count_nxt = count;
    if (wr_en && !pop)      count_nxt = count + CW'(1);
    else if (!wr_en && pop) count_nxt = count - CW'(1);
    flags_nxt.empty        = (count_nxt == '0);
    flags_nxt.full         = (count_nxt == CW'(DEPTH));
    flags_nxt.almost_empty = (count_nxt <= AE_TH);
    flags_nxt.almost_full  = (count_nxt >= AF_TH);
  end

  hs_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st        <= TX_IDLE;
      rx_st        <= RX_IDLE;
      tx_done      <= 1'b0;
      rx_rdy       <= 1'b0;
      out_data     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      case (tx_st)
        TX_IDLE:
          if (push) begin
            tx_done <= 1'b1;
            tx_st   <= TX_ACK;
          end else begin
            tx_done <= 1'b0;
          end
        TX_ACK:
          if (!tx_rdy) begin
            tx_done <= 1'b0;
            tx_st   <= TX_IDLE;
          end
        default: tx_st <= TX_IDLE;
      endcase

      case (rx_st)
        RX_IDLE:
          if (!empty) begin
            out_data <= rd_word;
            rx_rdy   <= 1'b1;
            rx_st    <= RX_VALID;
          end else begin
            rx_rdy <= 1'b0;
          end
        RX_VALID:
          if (rx_done) begin
            rx_rdy <= 1'b0;
            rx_st  <= RX_WAIT;
          end
        RX_WAIT:
          if (!rx_done) rx_st <= RX_IDLE;
        default: rx_st <= RX_IDLE;
      endcase

      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      count        <= count_nxt;
      empty        <= flags_nxt.empty;
      full         <= flags_nxt.full;
      almost_empty <= flags_nxt.almost_empty;
      almost_full  <= flags_nxt.almost_full;

      // Flush wins over everything on the storage/RX side; TX still acknowledges.
      if (flush) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
        empty        <= 1'b1;
        full         <= 1'b0;
        almost_empty <= 1'b1;
        almost_full  <= 1'b0;
        rx_rdy       <= 1'b0;
        rx_st        <= RX_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_hs_fifo.sv
// Scoreboard bench for hs_fifo: directed handshake corners plus a randomized stream.
module tb_hs_fifo;
  import hs_fifo_pkg::*;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int CW = clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_rdy = 1'b0;
  logic          rx_done = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          tx_done, rx_rdy, empty, full, almost_empty, almost_full;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;
`ifdef HS_FIFO_FLUSH_EN
  logic          flush = 1'b0;
`endif

  int           errs = 0;
  int           checks = 0;
  int           n_seen = 0;
  logic         mon_prev = 1'b0;
  logic         inv_en = 1'b0;
  logic [W-1:0] exp_q[$];

  hs_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_rdy       (tx_rdy),
    .in_data      (in_data),
    .tx_done      (tx_done),
    .rx_rdy       (rx_rdy),
    .rx_done      (rx_done),
    .out_data     (out_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count)
`ifdef HS_FIFO_FLUSH_EN
    ,
    .flush        (flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bounded wait: sel 0 watches tx_done, sel 1 watches rx_rdy.
  task automatic wait_for(input int sel, input logic v, input string name);
    int n;
    n = 0;
    while (((sel == 0) ? tx_done : rx_rdy) !== v && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (((sel == 0) ? tx_done : rx_rdy) !== v) begin
      checks++;
      errs++;
      $display("FAIL %s: timeout, signal still %0b expected %0b", name, ~v, v);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    tx_rdy  = 1'b1;
    in_data = d;
    @(negedge clk);
    wait_for(0, 1'b1, "push_ack");
    if (tx_done) exp_q.push_back(d);
    tx_rdy = 1'b0;
    @(negedge clk);
    wait_for(0, 1'b0, "push_release");
  endtask

  task automatic pop_one(input int delay);
    wait_for(1, 1'b1, "pop_rdy");
    repeat (delay) @(negedge clk);
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every fresh presentation of a head word must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_rdy === 1'b1 && mon_prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL order: got %0h expected no word", out_data);
        end else begin
          chk("order", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
          n_seen++;
        end
      end
      mon_prev = rx_rdy;
    end
  end

  // Flag rules restated from occupancy and thresholds (AFULL=4, AEMPTY=1).
  always @(negedge clk) begin
    if (inv_en && !rst) begin
      chk("cnt_le_depth", 32'(count <= CW'(D)), 32'd1);
      chk("flag_rules", {28'b0, empty, full, almost_empty, almost_full},
          {28'b0, count == 0, count == CW'(D), count <= 1, count >= 4});
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_flags", {28'b0, empty, full, almost_empty, almost_full}, 32'b1010);
    chk("rst_hs", {30'b0, tx_done, rx_rdy}, 0);
    chk("rst_out", 32'(out_data), 0);
    rst = 1'b0;
    inv_en = 1'b1;

    // Fill to full.
    for (int i = 1; i <= 5; i++) push_word(W'(i * 'h11));
    chk("full_count", 32'(count), 5);
    chk("full_flags", {28'b0, empty, full, almost_empty, almost_full}, 32'b0101);

    // Sixth push blocked until a pop completes, and not accepted on the pop edge.
    tx_rdy = 1'b1;
    in_data = 8'h66;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("blocked_tx_done", 32'(tx_done), 0);
    end
    rx_done = 1'b1;
    @(negedge clk);
    chk("pop_edge_count", 32'(count), 4);
    chk("pop_edge_no_push", 32'(tx_done), 0);
    rx_done = 1'b0;
    @(negedge clk);
    chk("late_push_ack", 32'(tx_done), 1);
    chk("late_push_count", 32'(count), 5);
    if (tx_done) exp_q.push_back(8'h66);
    tx_rdy = 1'b0;
    @(negedge clk);
    wait_for(0, 1'b0, "push6_release");

    // Drain everything.
    for (int i = 0; i < 5; i++) pop_one(i % 2);
    chk("drain_count", 32'(count), 0);
    chk("drain_empty", 32'(empty), 1);

    // Simultaneous push and pop at count 4.
    for (int i = 1; i <= 4; i++) push_word(8'hA0 + W'(i));
    wait_for(1, 1'b1, "af_rdy");
    chk("af_before", {30'b0, almost_full, 1'b0} | 32'(count << 2), 32'b10010);
    tx_rdy = 1'b1;
    in_data = 8'hA5;
    rx_done = 1'b1;
    @(negedge clk);
    chk("pushpop_count", 32'(count), 4);
    chk("pushpop_af", 32'(almost_full), 1);
    chk("pushpop_ack", 32'(tx_done), 1);
    if (tx_done) exp_q.push_back(8'hA5);
    tx_rdy = 1'b0;
    rx_done = 1'b0;
    @(negedge clk);
    wait_for(0, 1'b0, "pushpop_release");

    // Reset mid-handshake with count 3 and producer still requesting.
    pop_one(0);
    wait_for(1, 1'b1, "rst_pre_rdy");
    chk("pre_rst_count", 32'(count), 3);
    rst = 1'b1;
    tx_rdy = 1'b1;
    in_data = 8'hB7;
    @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    chk("midrst_hs", {30'b0, tx_done, rx_rdy}, 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_empty", 32'(empty), 1);
    @(negedge clk);
    chk("post_rst_push", 32'(tx_done), 1);
    if (tx_done) exp_q.push_back(8'hB7);
    tx_rdy = 1'b0;
    @(negedge clk);
    wait_for(0, 1'b0, "post_rst_release");
    pop_one(1);

`ifdef HS_FIFO_FLUSH_EN
    for (int i = 1; i <= 3; i++) push_word(8'hC0 + W'(i));
    wait_for(1, 1'b1, "flush_pre_rdy");
    flush = 1'b1;
    tx_rdy = 1'b1;
    in_data = 8'hAA;
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_rx_rdy", 32'(rx_rdy), 0);
    chk("flush_tx_ack", 32'(tx_done), 1);
    tx_rdy = 1'b0;
    @(negedge clk);
    wait_for(0, 1'b0, "flush_release");
    push_word(8'h5A);
    pop_one(0);
`endif

    // Randomized overlapping stream.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          push_word(W'($urandom));
        end
      end
      begin
        for (int i = 0; i < 30; i++) pop_one(int'($urandom_range(0, 3)));
      end
    join
    repeat (3) @(negedge clk);
    chk("rand_drained", 32'(exp_q.size()), 0);
    chk("rand_count", 32'(count), 0);
    chk("seen_any", 32'(n_seen > 30), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/hs_fifo.md
HS_FIFO -- requirements
Module: hs_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 5: storage words; any value >= 2, not restricted to powers of two.
REQ-003 Parameter AFULL_THRESH, default DEPTH-1: almost_full asserts when count >= AFULL_THRESH.
REQ-004 Parameter AEMPTY_THRESH, default 1: almost_empty asserts when count <= AEMPTY_THRESH.
REQ-005 Pointer width SHALL be derived as clog2(DEPTH); count width SHALL be clog2(DEPTH+1); neither is a user parameter.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 tx_rdy  input  1  producer holds in_data valid and requests a push.
REQ-009 in_data  input  WIDTH  push data.
REQ-010 tx_done  output  1  push accepted; four-phase acknowledge.
REQ-011 rx_rdy  output  1  out_data valid for consumer.
REQ-012 rx_done  input  1  consumer has taken out_data; four-phase acknowledge.
REQ-013 out_data  output  WIDTH  head word, registered.
REQ-014 empty, full, almost_empty, almost_full  output  1 each  registered status flags.
REQ-015 count  output  clog2(DEPTH+1)  words stored.

Function
REQ-016 TX FSM SHALL have states TX_IDLE and TX_ACK.
REQ-017 TX_IDLE with tx_rdy=1 and full=0 SHALL write in_data to mem[wr_ptr] at that edge, set tx_done=1, go to TX_ACK; otherwise stay, tx_done=0.
REQ-018 TX_ACK SHALL hold tx_done=1 while tx_rdy=1; on tx_rdy=0 it SHALL clear tx_done and return to TX_IDLE; no further write occurs in TX_ACK.
REQ-019 RX FSM SHALL have states RX_IDLE, RX_VALID, RX_WAIT.
REQ-020 RX_IDLE with empty=0 SHALL load out_data<=mem[rd_ptr], set rx_rdy=1, go to RX_VALID; otherwise stay, rx_rdy=0.
REQ-021 RX_VALID with rx_done=1 SHALL clear rx_rdy, pop (rd_ptr advance, count decrement) at that edge, go to RX_WAIT; otherwise hold rx_rdy and out_data.
REQ-022 RX_WAIT SHALL stay until rx_done=0, then return to RX_IDLE.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-024 Push and pop on the same edge SHALL leave count and all flags unchanged while both pointers advance.
REQ-025 Flags SHALL be updated on the same edge as count, from the next count value; a push is never accepted while full=1, even if a pop occurs that edge (accepted one cycle later).
REQ-026 Latency: push at edge N into empty FIFO -> empty=0 after N, rx_rdy=1 with that word after N+1.
REQ-027 Words SHALL emerge in strict push order; no word lost or duplicated.

Reset
REQ-028 rst=1 at an edge SHALL set both FSMs to idle, pointers and count to 0, tx_done=0, rx_rdy=0, out_data=0, empty=1, almost_empty=1, full=0, almost_full=0; memory contents are not cleared.
REQ-029 Reset mid-handshake SHALL discard the in-flight transfer; a producer still holding tx_rdy=1 after reset is treated as a new request.

Configuration
REQ-030 Macro HS_FIFO_FLUSH_EN defined SHALL add input flush (1 bit): flush=1 at an edge zeroes pointers and count, sets empty/almost_empty=1, full/almost_full=0, rx_rdy=0, RX FSM to RX_IDLE; it overrides a same-edge push (data discarded, tx_done still asserted) and pop.
REQ-031 Macro undefined SHALL omit the flush port; behaviour identical to flush tied 0.

Structure
REQ-032 Package hs_fifo_pkg SHALL hold TX/RX state encodings and the clog2 helper.
REQ-033 Storage SHALL be sub-module hs_fifo_mem: WIDTH x DEPTH register array, one synchronous write port, one asynchronous read port.

Verification
REQ-034 WIDTH=8, DEPTH=5: push 0x11..0x55 -> full=1 after 5th push, count=5; 6th tx_rdy held, tx_done stays 0 until one pop completes.
REQ-035 Pop all 5 -> out_data 0x11,0x22,0x33,0x44,0x55 in order; empty=1, count=0 after last rx_done edge.
REQ-036 Steady stream of 12 words with overlapping push/pop -> pointer wrap exercised, count never exceeds 5, order preserved.
REQ-037 count=4, push and pop on same edge -> count stays 4, almost_full stays 1 (AFULL_THRESH=4).
REQ-038 rst=1 during RX_VALID with count=3 -> next cycle rx_rdy=0, count=0, empty=1, tx_done=0.
REQ-039 HS_FIFO_FLUSH_EN: flush at count=3 concurrent with push 0xAA -> count=0, empty=1, 0xAA never emerges.
